// File: rtl/haar_stage_param_assembler.sv
// Consumer end of the per-stage classifier database stream: pulls 12-bit words from the
// database FIFO, packs them into per-classifier records, then captures the stage thresholds.
module haar_stage_param_assembler #(
  parameter int unsigned DATA_WIDTH_12            = 12,
  parameter int unsigned ADDR_WIDTH               = 12,
  parameter int unsigned NUM_CLASSIFIERS_STAGE    = 32,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int unsigned NUM_STAGE_THRESHOLD      = 3
) (
  input  logic                                              clk_fpga,
  input  logic                                              reset_fpga,
  input  logic                                              i_start,
  output logic                                              o_rden,
  input  logic [DATA_WIDTH_12-1:0]                          i_data_database,
  input  logic                                              i_end_count_database_index,
  output logic                                              o_classifier_valid,
  input  logic                                              i_classifier_ready,
  output logic [DATA_WIDTH_12*NUM_PARAM_PER_CLASSIFIER-1:0] o_classifier_params,
  output logic [ADDR_WIDTH-1:0]                             o_classifier_index,
  output logic                                              o_stage_threshold_valid,
  output logic [DATA_WIDTH_12*NUM_STAGE_THRESHOLD-1:0]      o_stage_threshold,
  output logic                                              o_stage_done,
  output logic                                              o_error
);

  localparam int unsigned PARAMS_W = DATA_WIDTH_12 * NUM_PARAM_PER_CLASSIFIER;
  localparam int unsigned THR_W    = DATA_WIDTH_12 * NUM_STAGE_THRESHOLD;

  localparam logic [ADDR_WIDTH-1:0] CLS_WORDS = ADDR_WIDTH'(NUM_PARAM_PER_CLASSIFIER);
  localparam logic [ADDR_WIDTH-1:0] THR_WORDS = ADDR_WIDTH'(NUM_STAGE_THRESHOLD);
  localparam logic [ADDR_WIDTH-1:0] LAST_CLS  = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_CLS,
    ST_HOLD_CLS,
    ST_FETCH_THR,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   issued_q, issued_d;
  logic [ADDR_WIDTH-1:0]   slot_q, slot_d;
  logic                    rden_q, rden_d;
  logic                    rd_pending_q, rd_pending_d;
  logic [PARAMS_W-1:0]     params_q, params_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic                    valid_q, valid_d;
  logic [THR_W-1:0]        thr_q, thr_d;
  logic                    thr_valid_q, thr_valid_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    final_word_c;

  // State and datapath registers; reset also aborts any fetch in flight.
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q      <= ST_IDLE;
      issued_q     <= '0;
      slot_q       <= '0;
      rden_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      params_q     <= '0;
      index_q      <= '0;
      valid_q      <= 1'b0;
      thr_q        <= '0;
      thr_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      slot_q       <= slot_d;
      rden_q       <= rden_d;
      rd_pending_q <= rd_pending_d;
      params_q     <= params_d;
      index_q      <= index_d;
      valid_q      <= valid_d;
      thr_q        <= thr_d;
      thr_valid_q  <= thr_valid_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Sequencing: issued_q counts read enables already driven for the current record,
  // slot_q counts words already captured for it.
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    slot_d       = slot_q;
    rden_d       = 1'b0;
    rd_pending_d = rden_q;
    params_d     = params_q;
    index_d      = index_q;
    valid_d      = valid_q;
    thr_d        = thr_q;
    thr_valid_d  = thr_valid_q;
    done_d       = 1'b0;
    error_d      = error_q;
    final_word_c = (state_q == ST_FETCH_THR) && (slot_q == THR_WORDS - ONE);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_FETCH_CLS;
          rden_d      = 1'b1;
          issued_d    = ONE;
          slot_d      = '0;
          index_d     = '0;
          thr_valid_d = 1'b0;
        end
      end

      ST_FETCH_CLS: begin
        rden_d = (issued_q < CLS_WORDS);
        if (rden_d) issued_d = issued_q + ONE;
        if (rd_pending_q) begin
          for (int unsigned k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) begin
            if (slot_q == ADDR_WIDTH'(k)) params_d[k*DATA_WIDTH_12 +: DATA_WIDTH_12] = i_data_database;
          end
          slot_d = slot_q + ONE;
          if (slot_q == CLS_WORDS - ONE) begin
            state_d = ST_HOLD_CLS;
            valid_d = 1'b1;
          end
        end
      end

      ST_HOLD_CLS: begin
        if (valid_q && i_classifier_ready) begin
          valid_d  = 1'b0;
          index_d  = index_q + ONE;
          rden_d   = 1'b1;
          issued_d = ONE;
          slot_d   = '0;
          state_d  = (index_q == LAST_CLS) ? ST_FETCH_THR : ST_FETCH_CLS;
        end
      end

      ST_FETCH_THR: begin
        rden_d = (issued_q < THR_WORDS);
        if (rden_d) issued_d = issued_q + ONE;
        if (rd_pending_q) begin
          for (int unsigned t = 0; t < NUM_STAGE_THRESHOLD; t++) begin
            if (slot_q == ADDR_WIDTH'(t)) thr_d[t*DATA_WIDTH_12 +: DATA_WIDTH_12] = i_data_database;
          end
          slot_d = slot_q + ONE;
          if (final_word_c) begin
            state_d     = ST_DONE;
            thr_valid_d = 1'b1;
            done_d      = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // End flag must accompany exactly the final threshold word; mismatch is sticky.
    if (rd_pending_q && (i_end_count_database_index != final_word_c)) error_d = 1'b1;
  end

  assign o_rden                  = rden_q;
  assign o_classifier_valid      = valid_q;
  assign o_classifier_params     = params_q;
  assign o_classifier_index      = index_q;
  assign o_stage_threshold_valid = thr_valid_q;
  assign o_stage_threshold       = thr_q;
  assign o_stage_done            = done_q;
  assign o_error                 = error_q;

endmodule
